// File: rtl/mix_engine_if.sv
// SDRAM read port and audio stream of the mix engine, bundled as one interface.
// The engine drives through the master modport; SDRAM model/arbiter and audio sink use slave.
interface mix_engine_if #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 23
);
    logic                    mix_read;
    logic [ADDR_W-1:0]       mix_addr;
    logic [2*SAMPLE_W-1:0]   mix_readdata;
    logic                    mix_sdram_finished;
    logic                    mix_audio_valid;
    logic [2*SAMPLE_W-1:0]   mix_audio_data;
    logic                    mix_audio_ready;

    modport master (
        output mix_read, mix_addr, mix_audio_valid, mix_audio_data,
        input  mix_readdata, mix_sdram_finished, mix_audio_ready
    );

    modport slave (
        input  mix_read, mix_addr, mix_audio_valid, mix_audio_data,
        output mix_readdata, mix_sdram_finished, mix_audio_ready
    );
endinterface

// File: rtl/mix_engine.sv
// N-channel SDRAM-fed stereo mixer: header/fetch rounds, per-half summing, repeated audio output.
// Optional macro MIX_SATURATE_EN clamps each summed half instead of wrapping.
module mix_engine #(
    parameter int N_CH     = 4,
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 23,
    parameter int REPEAT   = 2,
    parameter int READ_GAP = 8   // must be at least 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_CH-1:0]          mix_start_ch,
    input  logic [N_CH*ADDR_W-1:0]   mix_select,
    input  logic                     mix_stop,
    output logic                     mix_done,
    output logic [N_CH-1:0]          mix_active,
    mix_engine_if.master             bus
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int DW    = 2 * SAMPLE_W;
    localparam int GAP_W = $clog2(READ_GAP + 1);
    localparam int REP_W = 4;
`ifdef MIX_SATURATE_EN
    localparam int SUM_W = SAMPLE_W + CH_W;
    localparam logic signed [SUM_W-1:0] S_MAX = SUM_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] S_MIN = ~S_MAX;
`else
    // Wrapping keeps only the low SAMPLE_W bits, so the adder needs no headroom.
    localparam int SUM_W = SAMPLE_W;
`endif

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_FETCH, S_GAP, S_SUM, S_PLAY} state_t;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0]        rep_cnt_q, rep_cnt_d;
    logic                    hdr_gap_q, hdr_gap_d;
    logic                    round_act_q, round_act_d;
    logic [ADDR_W-1:0]       base_q [N_CH];
    logic [ADDR_W-1:0]       base_d [N_CH];
    logic [ADDR_W-1:0]       addr_q [N_CH];
    logic [ADDR_W-1:0]       addr_d [N_CH];
    logic [ADDR_W-1:0]       end_q  [N_CH];
    logic [ADDR_W-1:0]       end_d  [N_CH];
    logic [DW-1:0]           smp_q  [N_CH];
    logic [DW-1:0]           smp_d  [N_CH];
    logic [N_CH-1:0]         active_q, active_d;
    logic [N_CH-1:0]         pending_q, pending_d;
    logic [DW-1:0]           audio_data_q, audio_data_d;
    logic                    audio_valid_q, audio_valid_d;
    logic                    done_q, done_d;
`ifdef MIX_SATURATE_EN
    logic                    ovf_q, ovf_d;
    logic                    clamp_hit;
`endif

    logic [CH_W-1:0]         first_pend;
    logic signed [SUM_W-1:0] sum_l, sum_r;
    logic [SAMPLE_W-1:0]     mix_l, mix_r;
    logic [ADDR_W-1:0]       hdr_len, addr_inc;
    logic                    last_ch;

    assign bus.mix_read        = (state_q == S_HEADER) || (state_q == S_FETCH && active_q[ch_q]);
    assign bus.mix_addr        = (state_q == S_HEADER) ? base_q[ch_q] : addr_q[ch_q];
    assign bus.mix_audio_valid = audio_valid_q;
    assign bus.mix_audio_data  = audio_data_q;
    assign mix_done            = done_q;
    assign mix_active          = active_q;

    assign hdr_len  = bus.mix_readdata[ADDR_W-1:0];
    assign addr_inc = (state_q == S_HEADER) ? base_q[ch_q] + 1'b1 : addr_q[ch_q] + 1'b1;
    assign last_ch  = (ch_q == CH_W'(N_CH - 1));

    always_comb begin
        first_pend = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (pending_q[c]) first_pend = CH_W'(c);
        end
    end

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int c = 0; c < N_CH; c++) begin
            sum_l = sum_l + SUM_W'($signed(smp_q[c][DW-1:SAMPLE_W]));
            sum_r = sum_r + SUM_W'($signed(smp_q[c][SAMPLE_W-1:0]));
        end
    end

`ifdef MIX_SATURATE_EN
    always_comb begin
        mix_l = (sum_l > S_MAX) ? S_MAX[SAMPLE_W-1:0] :
                (sum_l < S_MIN) ? S_MIN[SAMPLE_W-1:0] : sum_l[SAMPLE_W-1:0];
        mix_r = (sum_r > S_MAX) ? S_MAX[SAMPLE_W-1:0] :
                (sum_r < S_MIN) ? S_MIN[SAMPLE_W-1:0] : sum_r[SAMPLE_W-1:0];
        clamp_hit = (sum_l > S_MAX) || (sum_l < S_MIN) || (sum_r > S_MAX) || (sum_r < S_MIN);
    end
`else
    assign mix_l = sum_l;
    assign mix_r = sum_r;
`endif

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        gap_cnt_d     = gap_cnt_q;
        rep_cnt_d     = rep_cnt_q;
        hdr_gap_d     = hdr_gap_q;
        round_act_d   = round_act_q;
        base_d        = base_q;
        addr_d        = addr_q;
        end_d         = end_q;
        smp_d         = smp_q;
        active_d      = active_q;
        pending_d     = pending_q;
        audio_data_d  = audio_data_q;
        audio_valid_d = audio_valid_q;
`ifdef MIX_SATURATE_EN
        ovf_d         = (state_q == S_IDLE) ? 1'b0 : ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    state_d = S_HEADER;
                    ch_d    = first_pend;
                end
            end
            S_HEADER: begin
                if (bus.mix_sdram_finished) begin
                    addr_d[ch_q]    = addr_inc;
                    end_d[ch_q]     = addr_inc + hdr_len;
                    active_d[ch_q]  = (hdr_len != '0);
                    pending_d[ch_q] = 1'b0;
                    hdr_gap_d       = 1'b1;
                    gap_cnt_d       = '0;
                    state_d         = S_GAP;
                end
            end
            S_FETCH: begin
                if (!active_q[ch_q]) begin
                    smp_d[ch_q] = '0;
                    state_d     = last_ch ? S_SUM : S_FETCH;
                    ch_d        = last_ch ? ch_q : ch_q + 1'b1;
                end else if (bus.mix_sdram_finished) begin
                    smp_d[ch_q]  = bus.mix_readdata;
                    addr_d[ch_q] = addr_inc;
                    if (addr_inc == end_q[ch_q]) active_d[ch_q] = 1'b0;
                    hdr_gap_d    = 1'b0;
                    gap_cnt_d    = '0;
                    state_d      = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q != GAP_W'(READ_GAP - 1)) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end else if (hdr_gap_q) begin
                    // Drain all pending headers before the round starts.
                    if (|pending_q) begin
                        state_d = S_HEADER;
                        ch_d    = first_pend;
                    end else begin
                        state_d     = S_FETCH;
                        ch_d        = '0;
                        round_act_d = |active_q;
                    end
                end else begin
                    state_d = last_ch ? S_SUM : S_FETCH;
                    ch_d    = last_ch ? ch_q : ch_q + 1'b1;
                end
            end
            S_SUM: begin
                if (round_act_q) begin
                    audio_data_d  = {mix_l, mix_r};
                    audio_valid_d = 1'b1;
                    rep_cnt_d     = '0;
                    state_d       = S_PLAY;
`ifdef MIX_SATURATE_EN
                    if (clamp_hit) ovf_d = 1'b1;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (audio_valid_q && bus.mix_audio_ready) begin
                    if (rep_cnt_q == REP_W'(REPEAT - 1)) begin
                        audio_valid_d = 1'b0;
                        rep_cnt_d     = '0;
                        ch_d          = '0;
                        round_act_d   = |active_q;
                        if (|pending_q) begin
                            state_d = S_HEADER;
                            ch_d    = first_pend;
                        end else if (|active_q) begin
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Starts land in base_q so a running channel keeps its own address until re-headered.
        if (!mix_stop) begin
            for (int c = 0; c < N_CH; c++) begin
                if (mix_start_ch[c]) begin
                    pending_d[c] = 1'b1;
                    base_d[c]    = mix_select[c*ADDR_W +: ADDR_W];
                end
            end
        end else begin
            active_d      = '0;
            pending_d     = '0;
            rep_cnt_d     = '0;
            audio_valid_d = 1'b0;
            state_d       = S_IDLE;
        end

        done_d = (state_d == S_IDLE) && (state_q != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            gap_cnt_q     <= '0;
            rep_cnt_q     <= '0;
            hdr_gap_q     <= 1'b0;
            round_act_q   <= 1'b0;
            active_q      <= '0;
            pending_q     <= '0;
            audio_data_q  <= '0;
            audio_valid_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef MIX_SATURATE_EN
            ovf_q         <= 1'b0;
`endif
            for (int c = 0; c < N_CH; c++) begin
                base_q[c] <= '0;
                addr_q[c] <= '0;
                end_q[c]  <= '0;
                smp_q[c]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            gap_cnt_q     <= gap_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            hdr_gap_q     <= hdr_gap_d;
            round_act_q   <= round_act_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            audio_data_q  <= audio_data_d;
            audio_valid_q <= audio_valid_d;
            done_q        <= done_d;
`ifdef MIX_SATURATE_EN
            ovf_q         <= ovf_d;
`endif
            base_q        <= base_d;
            addr_q        <= addr_d;
            end_q         <= end_d;
            smp_q         <= smp_d;
        end
    end
endmodule

// File: tb/tb_mix_engine.sv
// Self-checking bench for mix_engine: SDRAM memory model, audio sink and a frame-level mixing model.
module tb_mix_engine;
    localparam int N_CH = 4, SW = 16, AW = 23, REPEAT = 2, READ_GAP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_CH-1:0]    start_ch = '0;
    logic [N_CH*AW-1:0] select   = '0;
    logic               stop     = 1'b0;
    logic               done;
    logic [N_CH-1:0]    active;

    always #5 clk = ~clk;

    mix_engine_if #(.SAMPLE_W(SW), .ADDR_W(AW)) bus ();

    mix_engine #(.N_CH(N_CH), .SAMPLE_W(SW), .ADDR_W(AW), .REPEAT(REPEAT), .READ_GAP(READ_GAP)) dut (
        .i_clk(clk), .i_rst(rst), .mix_start_ch(start_ch), .mix_select(select),
        .mix_stop(stop), .mix_done(done), .mix_active(active), .bus(bus)
    );

    int checks = 0, errors = 0;

    // SDRAM model: answers after lat extra cycles unless hold is set.
    logic [31:0] mem [0:4095];
    int   lat = 0, wait_cnt = 0;
    bit   hold = 0;
    logic sd_fin = 1'b0;
    logic [31:0] sd_data = '0;
    assign bus.mix_sdram_finished = sd_fin;
    assign bus.mix_readdata       = sd_data;

    always @(posedge clk) begin
        #1;
        if (bus.mix_read && !hold) begin
            if (wait_cnt >= lat) begin
                sd_fin  = 1'b1;
                sd_data = mem[bus.mix_addr[11:0]];
            end else begin
                wait_cnt++;
                sd_fin = 1'b0;
            end
        end else begin
            sd_fin   = 1'b0;
            wait_cnt = 0;
        end
    end

    // Audio sink: 0 = never ready, 1 = always ready, 2 = random.
    int   ready_mode = 0;
    logic ready_r = 1'b0;
    assign bus.mix_audio_ready = ready_r;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready_r = 1'b0;
            1:       ready_r = 1'b1;
            default: ready_r = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor, sampled on the falling edge.
    logic [31:0]   got_q[$];
    logic [AW-1:0] rd_addr_log[$];
    int            xfer_at_rd[$];
    int xfer_cnt = 0, rd_cnt = 0, done_cnt = 0, done_long = 0, addr_unstable = 0, rd_at_fall0 = -1;
    logic [N_CH-1:0] prev_active = '0;
    logic prev_read = 1'b0, prev_fin = 1'b0, prev_done = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (bus.mix_audio_valid && bus.mix_audio_ready) begin
            got_q.push_back(bus.mix_audio_data);
            xfer_cnt++;
        end
        if (bus.mix_read && bus.mix_sdram_finished) begin
            rd_cnt++;
            rd_addr_log.push_back(bus.mix_addr);
            xfer_at_rd.push_back(xfer_cnt);
        end
        if (bus.mix_read && prev_read && !prev_fin && bus.mix_addr != prev_addr) addr_unstable++;
        if (done) done_cnt++;
        if (done && prev_done) done_long++;
        if (prev_active[0] && !active[0]) rd_at_fall0 = rd_cnt;
        prev_active = active;
        prev_read   = bus.mix_read;
        prev_fin    = bus.mix_sdram_finished;
        prev_addr   = bus.mix_addr;
        prev_done   = done;
    end

    // Reference: sum the signed halves of every contributing word, then clamp or wrap.
    function automatic logic [31:0] model_mix(input logic [31:0] w[$]);
        int l = 0, r = 0;
        logic [31:0] lv, rv;
        foreach (w[i]) begin
            l += int'($signed(w[i][31:16]));
            r += int'($signed(w[i][15:0]));
        end
`ifdef MIX_SATURATE_EN
        if (l > 32767) l = 32767;
        if (l < -32768) l = -32768;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        lv = l;
        rv = r;
        return {lv[15:0], rv[15:0]};
    endfunction

    task automatic write_track(input int base, input logic [31:0] words[$]);
        mem[base] = words.size();
        foreach (words[i]) mem[base + 1 + i] = words[i];
    endtask

    task automatic do_reset();
        rst = 1'b1; start_ch = '0; stop = 1'b0; hold = 0; ready_mode = 0; lat = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_chans(input logic [N_CH-1:0] mask, input int b0, input int b1, input int b2, input int b3);
        @(posedge clk); #1;
        select[0*AW +: AW] = AW'(b0);
        select[1*AW +: AW] = AW'(b1);
        select[2*AW +: AW] = AW'(b2);
        select[3*AW +: AW] = AW'(b3);
        start_ch = mask;
        @(posedge clk); #1;
        start_ch = '0;
    endtask

    task automatic wait_done(input int budget, input int d0, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_cnt > d0) ok = 1;
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.mix_audio_valid) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.mix_read !== 1'b0) begin errors++; $display("FAIL reset_read got=%b want=0", bus.mix_read); end
        checks++; if (bus.mix_audio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.mix_audio_valid); end
        checks++; if (bus.mix_audio_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=0", bus.mix_audio_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (active !== '0) begin errors++; $display("FAIL reset_active got=%b want=0", active); end
        do_reset();
        @(negedge clk);
        checks++; if (bus.mix_read !== 1'b0 || bus.mix_addr !== '0) begin errors++; $display("FAIL idle_read got=%b/%h want=0/0", bus.mix_read, bus.mix_addr); end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        logic [31:0] s[$];
        logic [31:0] one[$];
        logic [31:0] exp;
        int g0, d0, r0;
        bit ok;
        s = {32'h0001_FFFF, 32'h7FFF_8000, 32'h1234_0000};
        do_reset();
        ready_mode = 1;
        write_track(32'h100, s);
        g0 = got_q.size(); d0 = done_cnt; r0 = rd_cnt;
        start_chans(4'b0001, 32'h100, 0, 0, 0);
        wait_done(2000, d0, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=no_done want=done"); end
        checks++; if (got_q.size() - g0 != 6) begin errors++; $display("FAIL single_count got=%0d want=6", got_q.size() - g0); end
        for (int j = 0; j < 6 && g0 + j < got_q.size(); j++) begin
            one = {s[j / 2]};
            exp = model_mix(one);
            checks++; if (got_q[g0 + j] !== exp) begin errors++; $display("FAIL single_frame%0d got=%h want=%h", j, got_q[g0 + j], exp); end
            $display("single: transfer %0d data=%h", j, got_q[g0 + j]);
        end
        checks++; if (rd_at_fall0 != r0 + 4) begin errors++; $display("FAIL single_active_fall got=%0d want=%0d", rd_at_fall0 - r0, 4); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done got=%0d want=1", done_cnt - d0); end
        checks++; if (active !== '0) begin errors++; $display("FAIL single_active_end got=%b want=0", active); end
    endtask

    task automatic test_saturate();
        logic [31:0] w[$];
        logic [31:0] exp;
        int g0, d0;
        bit ok;
        do_reset();
        ready_mode = 1;
        for (int c = 0; c < 4; c++) begin
            w = {32'h7000_9000};
            write_track(32'h200 + 16 * c, w);
        end
        w = {32'h7000_9000, 32'h7000_9000, 32'h7000_9000, 32'h7000_9000};
        exp = model_mix(w);
        g0 = got_q.size(); d0 = done_cnt;
        start_chans(4'b1111, 32'h200, 32'h210, 32'h220, 32'h230);
        wait_done(2000, d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_timeout got=no_done want=done"); end
        checks++; if (got_q.size() - g0 != REPEAT) begin errors++; $display("FAIL sat_count got=%0d want=%0d", got_q.size() - g0, REPEAT); end
        for (int j = 0; j < REPEAT && g0 + j < got_q.size(); j++) begin
            checks++; if (got_q[g0 + j] !== exp) begin errors++; $display("FAIL sat_frame%0d got=%h want=%h", j, got_q[g0 + j], exp); end
            $display("saturate: transfer %0d data=%h", j, got_q[g0 + j]);
        end
    endtask

    task automatic test_random_mix();
        for (int it = 0; it < 3; it++) begin
            logic [31:0] trk [N_CH][$];
            logic [31:0] w[$];
            logic [31:0] exp[$];
            logic [N_CH-1:0] mask;
            int len [N_CH];
            int maxlen, g0, d0, bad;
            bit ok;
            do_reset();
            lat = $urandom_range(0, 2);
            ready_mode = 2;
            mask = N_CH'($urandom_range(1, 15));
            maxlen = 0;
            for (int c = 0; c < N_CH; c++) begin
                trk[c] = {};
                len[c] = mask[c] ? int'($urandom_range(1, 4)) : 0;
                for (int k = 0; k < len[c]; k++) trk[c].push_back($urandom);
                if (len[c] > maxlen) maxlen = len[c];
                write_track(32'h800 + 32 * c, trk[c]);
            end
            exp = {};
            for (int k = 0; k < maxlen; k++) begin
                w = {};
                for (int c = 0; c < N_CH; c++) if (len[c] > k) w.push_back(trk[c][k]);
                for (int r = 0; r < REPEAT; r++) exp.push_back(model_mix(w));
            end
            g0 = got_q.size(); d0 = done_cnt;
            start_chans(mask, 32'h800, 32'h820, 32'h840, 32'h860);
            wait_done(5000, d0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got=no_done want=done", it); end
            checks++; if (got_q.size() - g0 != exp.size()) begin errors++; $display("FAIL rand%0d_count got=%0d want=%0d", it, got_q.size() - g0, exp.size()); end
            bad = 0;
            for (int j = 0; j < exp.size() && g0 + j < got_q.size(); j++) begin
                checks++;
                if (got_q[g0 + j] !== exp[j]) begin errors++; bad++; $display("FAIL rand%0d_frame%0d got=%h want=%h", it, j, got_q[g0 + j], exp[j]); end
            end
            $display("random: iter %0d mask=%b lat=%0d frames=%0d bad=%0d", it, mask, lat, exp.size(), bad);
        end
        ready_mode = 1;
    endtask

    task automatic test_staggered();
        logic [31:0] c0[$], c1[$], w[$], exp[$];
        int g0, d0, r0, x0, rv, hdr_x;
        bit ok;
        do_reset();
        for (int k = 0; k < 4; k++) c0.push_back($urandom);
        for (int k = 0; k < 2; k++) c1.push_back($urandom);
        write_track(32'h300, c0);
        write_track(32'h380, c1);
        for (int k = 0; k < 4; k++) begin
            w = {c0[k]};
            if (k >= 1 && k <= 2) w.push_back(c1[k - 1]);
            for (int r = 0; r < REPEAT; r++) exp.push_back(model_mix(w));
        end
        g0 = got_q.size(); d0 = done_cnt; r0 = rd_cnt; x0 = xfer_cnt;
        start_chans(4'b0001, 32'h300, 0, 0, 0);
        wait_valid(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stag_valid_timeout got=0 want=1"); end
        rv = rd_cnt;
        start_chans(4'b0010, 32'h300, 32'h380, 0, 0);
        repeat (5) @(negedge clk);
        checks++; if (rd_cnt != rv) begin errors++; $display("FAIL stag_read_in_play got=%0d want=%0d", rd_cnt - rv, 0); end
        ready_mode = 1;
        wait_done(3000, d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stag_timeout got=no_done want=done"); end
        hdr_x = -1;
        for (int i = r0; i < rd_addr_log.size(); i++) if (rd_addr_log[i] == AW'(32'h380) && hdr_x < 0) hdr_x = xfer_at_rd[i] - x0;
        checks++; if (hdr_x != REPEAT) begin errors++; $display("FAIL stag_hdr_after got=%0d want=%0d", hdr_x, REPEAT); end
        checks++; if (got_q.size() - g0 != exp.size()) begin errors++; $display("FAIL stag_count got=%0d want=%0d", got_q.size() - g0, exp.size()); end
        for (int j = 0; j < exp.size() && g0 + j < got_q.size(); j++) begin
            checks++; if (got_q[g0 + j] !== exp[j]) begin errors++; $display("FAIL stag_frame%0d got=%h want=%h", j, got_q[g0 + j], exp[j]); end
            $display("staggered: transfer %0d data=%h", j, got_q[g0 + j]);
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] none[$];
        int d0, r0, x0;
        bit ok;
        do_reset();
        ready_mode = 1;
        none = {};
        write_track(32'h400, none);
        d0 = done_cnt; r0 = rd_cnt; x0 = xfer_cnt;
        start_chans(4'b0100, 0, 0, 32'h400, 0);
        wait_done(500, d0, ok);
        repeat (5) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got=no_done want=done"); end
        checks++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL zero_reads got=%0d want=1", rd_cnt - r0); end
        checks++; if (xfer_cnt != x0) begin errors++; $display("FAIL zero_audio got=%0d want=0", xfer_cnt - x0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done got=%0d want=1", done_cnt - d0); end
        checks++; if (active !== '0) begin errors++; $display("FAIL zero_active got=%b want=0", active); end
        $display("zero_len: reads=%0d transfers=%0d", rd_cnt - r0, xfer_cnt - x0);
    endtask

    task automatic test_backpressure();
        logic [31:0] s[$], one[$];
        logic [31:0] exp0, held;
        int d0, r0, g0;
        bit ok;
        do_reset();
        for (int k = 0; k < 2; k++) s.push_back($urandom);
        write_track(32'h500, s);
        one = {s[0]};
        exp0 = model_mix(one);
        g0 = got_q.size(); d0 = done_cnt;
        start_chans(4'b0001, 32'h500, 0, 0, 0);
        wait_valid(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_valid_timeout got=0 want=1"); end
        held = bus.mix_audio_data;
        r0 = rd_cnt;
        checks++; if (held !== exp0) begin errors++; $display("FAIL bp_data got=%h want=%h", held, exp0); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mix_audio_valid !== 1'b1 || bus.mix_audio_data !== held) begin
                errors++; $display("FAIL bp_hold cyc%0d got=%b/%h want=1/%h", i, bus.mix_audio_valid, bus.mix_audio_data, held);
            end
        end
        checks++; if (rd_cnt != r0 || bus.mix_read !== 1'b0) begin errors++; $display("FAIL bp_reads got=%0d want=0", rd_cnt - r0); end
        ready_mode = 1;
        wait_done(1000, d0, ok);
        checks++; if (!ok || got_q.size() - g0 != 2 * REPEAT) begin errors++; $display("FAIL bp_count got=%0d want=%0d", got_q.size() - g0, 2 * REPEAT); end
        $display("backpressure: held=%h transfers=%0d", held, got_q.size() - g0);
    endtask

    task automatic test_stop();
        logic [31:0] s[$];
        int d0;
        bit ok, saw_read;
        do_reset();
        ready_mode = 1;
        hold = 1;
        for (int k = 0; k < 5; k++) s.push_back($urandom);
        write_track(32'h600, s);
        start_chans(4'b0001, 32'h600, 0, 0, 0);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.mix_read) ok = 1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL stop_read_timeout got=0 want=1"); end
        d0 = done_cnt;
        @(posedge clk); #1;
        stop = 1'b1; start_ch = 4'b0001;
        @(posedge clk); #1;
        stop = 1'b0; start_ch = '0;
        @(negedge clk);
        checks++; if (bus.mix_read !== 1'b0) begin errors++; $display("FAIL stop_read got=%b want=0", bus.mix_read); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stop_done got=%b want=1", done); end
        checks++; if (active !== '0 || bus.mix_audio_valid !== 1'b0) begin errors++; $display("FAIL stop_active got=%b/%b want=0/0", active, bus.mix_audio_valid); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done_width got=%b want=0", done); end
        hold = 0;
        saw_read = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mix_read) saw_read = 1;
        end
        checks++; if (saw_read) begin errors++; $display("FAIL stop_start_ignored got=read want=idle"); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL stop_done_count got=%0d want=1", done_cnt - d0); end
        $display("stop: read=%b active=%b dones=%0d", bus.mix_read, active, done_cnt - d0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturate();
        test_random_mix();
        test_staggered();
        test_zero_len();
        test_backpressure();
        test_stop();
        checks++; if (addr_unstable != 0) begin errors++; $display("FAIL addr_stable got=%0d want=0", addr_unstable); end
        checks++; if (done_long != 0) begin errors++; $display("FAIL done_pulse_width got=%0d want=0", done_long); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mix_engine.md
# mix_engine

Parametrised N-channel audio mixer between the playback controller, the SDRAM arbiter port and the audio DAC stream. Each channel plays a track stored in SDRAM as a length header followed by packed stereo samples. Every output frame is built in one fetch round: each active channel supplies one 32-bit word, the left and right halves are summed separately, and the result is streamed to the audio interface with a ready/valid handshake and a programmable sample-repeat factor. Channels start, finish and restart independently while the mix runs.

## Interface
- N_CH, 4, number of mix channels (2..8)
- SAMPLE_W, 16, bits per stereo half; a data word is 2*SAMPLE_W bits
- ADDR_W, 23, SDRAM word address width
- REPEAT, 2, number of times each mixed frame is presented to audio (1..15)
- READ_GAP, 8, idle cycles forced after each completed SDRAM read
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- mix_start_ch  in  N_CH  per-channel start pulse; bit c loads the base address for channel c
- mix_select  in  N_CH*ADDR_W  base addresses; channel c is [c*ADDR_W +: ADDR_W]
- mix_stop  in  1  abort all channels
- mix_done  out  1  one-cycle pulse when the engine returns to IDLE
- mix_active  out  N_CH  channel has samples remaining
- mix_read  out  1  SDRAM read request
- mix_addr  out  ADDR_W  SDRAM address
- mix_readdata  in  2*SAMPLE_W  read data, valid when mix_sdram_finished=1
- mix_sdram_finished  in  1  read complete
- mix_audio_valid  out  1  mixed frame available
- mix_audio_data  out  2*SAMPLE_W  mixed frame, signed: [2*SW-1:SW] left, [SW-1:0] right
- mix_audio_ready  in  1  audio sink accepts the frame

## Operation
- States: IDLE, HEADER, FETCH, GAP, SUM, PLAY.
- Start capture: a mix_start_ch bit sets pending[c] and latches addr[c]=mix_select[c]. This works in any state. Starting a channel that is already active restarts it.
- Pending service: pending channels are serviced at a round boundary (from IDLE, or from PLAY after the last repeat). Service is HEADER reads in ascending channel order; each is followed by GAP.
- Header read: the word at addr[c] has L = word[ADDR_W-1:0]. Then end[c]=addr[c]+1+L and addr[c]+=1. If L≠0, set active[c]; if L=0, active[c] stays 0.
- FETCH walks ch=0..N_CH-1:
  - Active channel: issue a read of addr[c]. On finished, store the word in smp[c], set addr[c]+=1, then go to GAP. If the new addr equals end[c], clear active[c].
  - Inactive channel: set smp[c]=0 and advance in 1 cycle with no read.
- After the last channel, go to SUM.
- SUM: each half is sign-extended to SAMPLE_W+clog2(N_CH) bits, summed over all channels, then reduced per Configuration. The result is registered into mix_audio_data.
- PLAY: valid is held high until the handshake fires REPEAT times. Data is held stable throughout. Then:
  - any pending: go to HEADER
  - else any active: go to FETCH
  - else: go to IDLE
- IDLE is also entered from FETCH/SUM if no channel was active at the round start. No frame is output in that case.
- mix_done pulses high for 1 cycle on every transition into IDLE from another state.
- mix_stop: highest priority, and takes effect the next cycle in any state. It clears active, pending and the repeat counter, forces IDLE, deasserts mix_read/mix_audio_valid and pulses mix_done. A start in the same cycle as stop is discarded.

## Timing
- Reset values: state=IDLE, all outputs 0, and all addr/end/smp/active/pending/counters 0.
- SDRAM handshake:
  - mix_read and mix_addr are stable from assertion until the cycle mix_sdram_finished=1. readdata is sampled in that cycle.
  - mix_read drops the next cycle and stays low for exactly READ_GAP cycles (GAP state).
  - mix_read stays high indefinitely if finished never comes.
- Audio handshake: transfer occurs when valid&&ready on a rising edge. Valid never drops without a transfer, except on stop or reset.
- Latency: with a 1-cycle SDRAM, start→first valid = (1+READ_GAP) per header + Σ over channels (active: 1+READ_GAP; inactive: 1) + 1 SUM + 1 cycles.
- Reset mid-read: mix_read drops asynchronously and the outstanding request is abandoned.

## Configuration
- MIX_SATURATE_EN defined:
  - each summed half is clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]
  - sticky internal overflow flag, cleared on IDLE
- Undefined: each half is the low SAMPLE_W bits of the sum (two's-complement wrap). No clamp logic is built.

## Test plan
- Single channel: ch0 base 0x100, header L=3, samples 0x0001_FFFF, 0x7FFF_8000, 0x1234_0000, REPEAT=2, ready=1.
  - Required: each frame is accepted twice, in order.
  - Required: mix_active[0] falls after the 3rd fetch.
  - Required: mix_done pulses once; 6 transfers total.
- Saturation: 4 channels, each L=1 with word 0x7000_9000.
  - With MIX_SATURATE_EN: output 0x7FFF_8000.
  - Without it: output 0xC000_4000.
- Staggered start: start ch1 during PLAY of ch0.
  - Required: ch1 header is read only after ch0's current frame completes REPEAT transfers.
  - Required: the next frame equals ch0+ch1.
- Zero-length header L=0 on ch2 alone: no data read, no audio valid, mix_done pulses after the header read and GAP.
- Backpressure: hold ready=0 for 20 cycles in PLAY.
  - Required: valid stays 1 with data stable.
  - Required: no SDRAM reads occur.
- Stop during a pending SDRAM read, issued together with start_ch=0001: mix_read falls next cycle, state is IDLE, the start is ignored, mix_done is a 1-cycle pulse, and mix_active is 0.
